// File: rtl/player_sprite_renderer.sv
// Player sprite renderer: draws the outlined player box and one obstacle box
// over a flat background, keeps the syncs aligned with the colour output
// (two pixel clocks of latency) and reports player/obstacle overlap once per frame.
module player_sprite_renderer #(
  parameter int          SPRITE_W   = 50,
  parameter int          SPRITE_H   = 50,
  parameter int          OBST_W     = 30,
  parameter int          OBST_H     = 40,
  parameter logic [15:0] PLAYER_X0  = 16'd300,
  parameter logic [15:0] PLAYER_Y0  = 16'd400,
  parameter logic [11:0] PLAYER_RGB = 12'hF80,
  parameter logic [11:0] BORDER_RGB = 12'hFFF,
  parameter logic [11:0] OBST_RGB   = 12'h0F0,
  parameter logic [11:0] BG_RGB     = 12'h008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pix_x,
  input  logic [15:0] pix_y,
  input  logic        pix_de,
  input  logic        pix_hs,
  input  logic        pix_vs,
  input  logic [15:0] x_player,
  input  logic [15:0] y_player,
  input  logic [15:0] x_obst,
  input  logic [15:0] y_obst,
  output logic [11:0] rgb,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic        collision,
  output logic [7:0]  hit_count
);

  localparam logic [16:0] SW = 17'(SPRITE_W);
  localparam logic [16:0] SH = 17'(SPRITE_H);
  localparam logic [16:0] OW = 17'(OBST_W);
  localparam logic [16:0] OH = 17'(OBST_H);

  logic        prev_vs;
  logic        frame_edge;
  logic [15:0] px, py, ox, oy;
  logic [16:0] x17, y17;
  logic [16:0] px_end, py_end, ox_end, oy_end;
  logic        in_player, on_border, in_obst;
  logic        s1_de, s1_hs, s1_vs, s1_in_player, s1_on_border, s1_in_obst;
  logic        s2_hs, s2_vs, s2_de;
  logic [11:0] colour;
  logic        frame_hit;

  assign frame_edge = pix_vs & ~prev_vs;

  // Box edges are formed at 17 bits so a box near the top of the
  // coordinate range extends past 16'hFFFF instead of wrapping to zero.
  assign x17    = {1'b0, pix_x};
  assign y17    = {1'b0, pix_y};
  assign px_end = {1'b0, px} + SW;
  assign py_end = {1'b0, py} + SH;
  assign ox_end = {1'b0, ox} + OW;
  assign oy_end = {1'b0, oy} + OH;

  assign in_player = (pix_x >= px) && (x17 < px_end) && (pix_y >= py) && (y17 < py_end);
  assign in_obst   = (pix_x >= ox) && (x17 < ox_end) && (pix_y >= oy) && (y17 < oy_end);
  assign on_border = in_player && ((pix_x == px) || (x17 == px_end - 17'd1) ||
                                   (pix_y == py) || (y17 == py_end - 17'd1));

  // Shadow positions: sampled only at the vsync rising edge so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_vs <= 1'b0;
      px      <= PLAYER_X0;
      py      <= PLAYER_Y0;
      ox      <= 16'd0;
      oy      <= 16'd0;
    end else begin
      prev_vs <= pix_vs;
      if (frame_edge) begin
        px <= x_player;
        py <= y_player;
        ox <= x_obst;
        oy <= y_obst;
      end
    end
  end

  // Stage 1: register timing and the box hits for the current pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_de        <= 1'b0;
      s1_hs        <= 1'b0;
      s1_vs        <= 1'b0;
      s1_in_player <= 1'b0;
      s1_on_border <= 1'b0;
      s1_in_obst   <= 1'b0;
    end else begin
      s1_de        <= pix_de;
      s1_hs        <= pix_hs;
      s1_vs        <= pix_vs;
      s1_in_player <= in_player;
      s1_on_border <= on_border;
      s1_in_obst   <= in_obst;
    end
  end

  // Colour priority: blanking, outline, player body, obstacle, background.
  always_comb begin
    colour = BG_RGB;
    if (!s1_de)            colour = 12'h000;
    else if (s1_on_border) colour = BORDER_RGB;
    else if (s1_in_player) colour = PLAYER_RGB;
    else if (s1_in_obst)   colour = OBST_RGB;
  end

  // Stage 2: register colour and the twice-delayed syncs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb   <= 12'h000;
      s2_hs <= 1'b0;
      s2_vs <= 1'b0;
      s2_de <= 1'b0;
    end else begin
      rgb   <= colour;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
      s2_de <= s1_de;
    end
  end

  assign hs_out = s2_hs;
  assign vs_out = s2_vs;
  assign de_out = s2_de;

  // Overlap tracking: the frame edge reports and clears, and wins over a same-cycle hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_hit <= 1'b0;
      collision <= 1'b0;
      hit_count <= 8'd0;
    end else if (frame_edge) begin
      collision <= frame_hit;
      frame_hit <= 1'b0;
      if (frame_hit && (hit_count != 8'd255)) hit_count <= hit_count + 8'd1;
    end else begin
      collision <= 1'b0;
      if (s1_de && s1_in_player && s1_in_obst) frame_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Bench for player_sprite_renderer: directed pixels with hand-computed colours,
// frame-edge collision reports, sync delay and saturation/reset corner cases.
module tb_player_sprite_renderer;

  localparam int W = 52;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pix_x = '0, pix_y = '0;
  logic        pix_de = 1'b0, pix_hs = 1'b0, pix_vs = 1'b0;
  logic [15:0] x_player = 16'd300, y_player = 16'd400;
  logic [15:0] x_obst = 16'd1000, y_obst = 16'd1000;
  logic [11:0] rgb;
  logic        hs_out, vs_out, de_out, collision;
  logic [7:0]  hit_count;

  // Entry layout: [51:28] due cycle, [27] frame entry, [26] check rgb,
  // [25:14] rgb, [13] hs, [12] vs, [11] de, [10] collision, [9:2] hit_count.
  logic [W-1:0] exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_hits = 0;
  logic pending_hit = 1'b0;

  player_sprite_renderer dut (
    .clk(clk), .reset(reset),
    .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs),
    .x_player(x_player), .y_player(y_player), .x_obst(x_obst), .y_obst(y_obst),
    .rgb(rgb), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
    .collision(collision), .hit_count(hit_count)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Drive one pixel at the falling edge and queue its expectations.
  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic de,
                       input logic hs, input logic vs, input logic chk_rgb,
                       input logic [11:0] want_rgb, input logic chk_frame,
                       input logic want_coll, input logic [7:0] want_hit);
    logic [W-1:0] e;
    @(negedge clk);
    pix_x = x; pix_y = y; pix_de = de; pix_hs = hs; pix_vs = vs;
    if (chk_frame) begin
      e = '0;
      e[51:28] = 24'(cyc + 1);
      e[27]    = 1'b1;
      e[10]    = want_coll;
      e[9:2]   = want_hit;
      exp_q.push_back(e);
    end
    e = '0;
    e[51:28] = 24'(cyc + 2);
    e[26]    = chk_rgb | ~de;
    e[25:14] = de ? want_rgb : 12'h000;
    e[13] = hs; e[12] = vs; e[11] = de;
    exp_q.push_back(e);
  endtask

  task automatic pixel(input logic [15:0] x, input logic [15:0] y, input logic [11:0] want);
    drive(x, y, 1'b1, 1'b0, 1'b0, 1'b1, want, 1'b0, 1'b0, 8'd0);
  endtask

  // Vsync pulse: the edge cycle reports the previous frame, the next cycle must be quiet.
  task automatic vsync();
    logic c;
    c = pending_hit;
    if (pending_hit && exp_hits != 255) exp_hits++;
    pending_hit = 1'b0;
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 8'd0);
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, c, 8'(exp_hits));
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 8'(exp_hits));
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 8'(exp_hits));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rgb"}, 32'(rgb), 32'h0);
    check({tag, "_sync"}, 32'({hs_out, vs_out, de_out}), 32'h0);
    check({tag, "_coll"}, 32'(collision), 32'h0);
    check({tag, "_hits"}, 32'(hit_count), 32'h0);
  endtask

  // Reset with whatever pixel inputs are currently applied; outputs must be zero next cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    pix_x = '0; pix_y = '0; pix_de = 1'b0; pix_hs = 1'b0; pix_vs = 1'b0;
    exp_hits = 0;
    pending_hit = 1'b0;
  endtask

  // Monitor: pops every expectation that falls due on this cycle.
  always @(posedge clk) begin
    logic [W-1:0] e;
    cyc = cyc + 1;
    #1;
    while (exp_q.size() > 0 && exp_q[0][51:28] <= 24'(cyc)) begin
      e = exp_q.pop_front();
      if (e[51:28] != 24'(cyc)) check("late_entry", 32'(e[51:28]), 32'(cyc));
      else if (e[27]) begin
        check("collision", 32'(collision), 32'(e[10]));
        check("hit_count", 32'(hit_count), 32'(e[9:2]));
      end else begin
        if (e[26]) check("rgb", 32'(rgb), 32'(e[25:14]));
        check("sync_delay", 32'({hs_out, vs_out, de_out}), 32'(e[13:11]));
      end
    end
  end

  // Directed scenarios.
  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // 1: outline, body, first column past the right edge.
    x_player = 16'd300; y_player = 16'd400; x_obst = 16'd1000; y_obst = 16'd1000;
    vsync();
    pixel(16'd300, 16'd400, 12'hFFF);
    pixel(16'd320, 16'd420, 12'hF80);
    pixel(16'd350, 16'd420, 12'h008);
    pixel(16'd349, 16'd449, 12'hFFF);

    // 2: mid-frame position change only takes effect at the next frame.
    x_player = 16'd100;
    pixel(16'd320, 16'd420, 12'hF80);
    vsync();
    pixel(16'd320, 16'd420, 12'h008);
    pixel(16'd120, 16'd420, 12'hF80);

    // 3: overlapping obstacle; player wins the overlap pixel.
    x_player = 16'd300; x_obst = 16'd330; y_obst = 16'd430;
    vsync();
    pixel(16'd335, 16'd435, 12'hF80);
    pixel(16'd340, 16'd460, 12'h0F0);
    pending_hit = 1'b1;

    // 4: disjoint obstacle; blanked pixel is black.
    x_obst = 16'd500;
    vsync();
    pixel(16'd505, 16'd435, 12'h0F0);
    drive(16'd320, 16'd420, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 8'd0);
    vsync();

    // 5: 260 overlapping frames saturate the counter.
    x_obst = 16'd330;
    vsync();
    for (int f = 0; f < 260; f++) begin
      pixel(16'd335, 16'd435, 12'hF80);
      pending_hit = 1'b1;
      vsync();
    end
    @(negedge clk);
    check("saturated", 32'(hit_count), 32'd255);
    pix_x = 16'd320; pix_y = 16'd420; pix_de = 1'b1; pix_hs = 1'b1; pix_vs = 1'b0;
    do_reset();

    // 6: random syncs must come out exactly two cycles later.
    x_player = 16'd300; y_player = 16'd400; x_obst = 16'd1000; y_obst = 16'd1000;
    for (int i = 0; i < 40; i++)
      drive(16'($urandom_range(0, 799)), 16'($urandom_range(0, 524)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'b0, 12'h000, 1'b0, 1'b0, 8'd0);
    x_player = 16'hFFF0;
    vsync();
    pixel(16'd5, 16'd400, 12'h008);
    pixel(16'hFFF5, 16'd410, 12'hF80);
    pixel(16'hFFFF, 16'd400, 12'hFFF);

    repeat (4) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
